// File: rtl/jtbubl_romarb.sv
// Shares one 16-bit SDRAM read port between three 8-bit ROM requesters.
// Each requester keeps a one-word cache; misses are fetched one at a time in round-robin order.
module jtbubl_romarb #(
  parameter int RAW = 16,
  parameter int SDW = 22,
  parameter logic [SDW-1:0] OFF0 = 22'h0,
  parameter logic [SDW-1:0] OFF1 = 22'h04000,
  parameter logic [SDW-1:0] OFF2 = 22'h06000
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           inv,
  input  logic           r0_cs,
  input  logic [RAW-1:0] r0_addr,
  output logic [7:0]     r0_data,
  output logic           r0_ok,
  input  logic           r1_cs,
  input  logic [RAW-1:0] r1_addr,
  output logic [7:0]     r1_data,
  output logic           r1_ok,
  input  logic           r2_cs,
  input  logic [RAW-1:0] r2_addr,
  output logic [7:0]     r2_data,
  output logic           r2_ok,
  output logic           sdram_req,
  output logic [SDW-1:0] sdram_addr,
  input  logic           sdram_ack,
  input  logic           data_rdy,
  input  logic [15:0]    data_din
);

  localparam int TW = RAW - 1;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_ACK  = 2'd1,
    ST_WAIT_DATA = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [2:0][TW-1:0]  r_tag;
  logic [2:0][15:0]    r_word;
  logic [2:0]          r_valid;
  logic                r_stale;
  logic [1:0]          r_nxt;
  logic [1:0]          r_gnt;
  logic [TW-1:0]       r_tag_if;

  logic [2:0]          w_cs;
  logic [2:0][TW-1:0]  w_waddr;
  logic [2:0]          w_bsel;
  logic [2:0]          w_hit;
  logic [2:0]          w_pend;
  logic                w_grant;
  logic                w_fill;
  logic                w_done;
  logic [1:0]          w_gnt_sel;
  logic [TW-1:0]       w_tag_sel;
  logic [SDW-1:0]      w_req_addr;

  function automatic logic [7:0] byte_sel(input logic [15:0] word, input logic sel);
    return sel ? word[15:8] : word[7:0];
  endfunction

  assign w_cs       = {r2_cs, r1_cs, r0_cs};
  assign w_waddr[0] = r0_addr[RAW-1:1];
  assign w_waddr[1] = r1_addr[RAW-1:1];
  assign w_waddr[2] = r2_addr[RAW-1:1];
  assign w_bsel     = {r2_addr[0], r1_addr[0], r0_addr[0]};

  // cache lookup per requester
  always_comb begin
    w_hit  = 3'b000;
    w_pend = 3'b000;
    for (int n = 0; n < 3; n++) begin
      w_hit[n]  = w_cs[n] && r_valid[n] && (r_tag[n] == w_waddr[n]);
      w_pend[n] = w_cs[n] && !w_hit[n];
    end
  end

  // round-robin pick starting at r_nxt, plus the SDRAM address and tag of the winner
  always_comb begin
    w_gnt_sel  = 2'd0;
    w_tag_sel  = w_waddr[0];
    w_req_addr = OFF0 + SDW'(w_waddr[0]);
    case (r_nxt)
      2'd0:    w_gnt_sel = w_pend[0] ? 2'd0 : (w_pend[1] ? 2'd1 : 2'd2);
      2'd1:    w_gnt_sel = w_pend[1] ? 2'd1 : (w_pend[2] ? 2'd2 : 2'd0);
      2'd2:    w_gnt_sel = w_pend[2] ? 2'd2 : (w_pend[0] ? 2'd0 : 2'd1);
      default: w_gnt_sel = 2'd0;
    endcase
    case (w_gnt_sel)
      2'd1: begin
        w_tag_sel  = w_waddr[1];
        w_req_addr = OFF1 + SDW'(w_waddr[1]);
      end
      2'd2: begin
        w_tag_sel  = w_waddr[2];
        w_req_addr = OFF2 + SDW'(w_waddr[2]);
      end
      default: begin
        w_tag_sel  = w_waddr[0];
        w_req_addr = OFF0 + SDW'(w_waddr[0]);
      end
    endcase
  end

  // next-state logic; a stale return completes the handshake without filling
  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_fill      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (|w_pend) begin
          w_grant     = 1'b1;
          w_state_nxt = ST_WAIT_ACK;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_WAIT_ACK: begin
        if (sdram_ack && data_rdy) begin
          w_fill      = !r_stale;
          w_state_nxt = ST_IDLE;
        end else if (sdram_ack) begin
          w_state_nxt = ST_WAIT_DATA;
        end else begin
          w_state_nxt = ST_WAIT_ACK;
        end
      end
      ST_WAIT_DATA: begin
        if (data_rdy) begin
          w_fill      = !r_stale;
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_WAIT_DATA;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    w_done = (r_state != ST_IDLE) && (w_state_nxt == ST_IDLE);
  end

  // FSM state, grant bookkeeping and the stale flag
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_gnt    <= 2'd0;
      r_nxt    <= 2'd0;
      r_tag_if <= '0;
      r_stale  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_grant) begin
        r_gnt    <= w_gnt_sel;
        r_tag_if <= w_tag_sel;
        r_nxt    <= (w_gnt_sel == 2'd2) ? 2'd0 : w_gnt_sel + 2'd1;
      end
      if (w_done) begin
        r_stale <= 1'b0;
      end else if (inv && (r_state != ST_IDLE)) begin
        r_stale <= 1'b1;
      end
    end
  end

  // SDRAM request; the address holds its last value once acknowledged
  always_ff @(posedge clk) begin
    if (rst) begin
      sdram_req  <= 1'b0;
      sdram_addr <= '0;
    end else if (w_grant) begin
      sdram_req  <= 1'b1;
      sdram_addr <= w_req_addr;
    end else if ((r_state == ST_WAIT_ACK) && sdram_ack) begin
      sdram_req  <= 1'b0;
    end
  end

  // cache fill always uses the tag latched at grant time; inv beats a same-cycle fill
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tag   <= '0;
      r_word  <= '0;
      r_valid <= 3'b000;
    end else begin
      for (int n = 0; n < 3; n++) begin
        if (w_fill && (r_gnt == 2'(n))) begin
          r_tag[n]  <= r_tag_if;
          r_word[n] <= data_din;
        end
        if (inv) begin
          r_valid[n] <= 1'b0;
        end else if (w_fill && (r_gnt == 2'(n))) begin
          r_valid[n] <= 1'b1;
        end
      end
    end
  end

  // registered requester outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r0_ok   <= 1'b0;
      r1_ok   <= 1'b0;
      r2_ok   <= 1'b0;
      r0_data <= 8'h00;
      r1_data <= 8'h00;
      r2_data <= 8'h00;
    end else begin
      r0_ok   <= w_hit[0];
      r1_ok   <= w_hit[1];
      r2_ok   <= w_hit[2];
      r0_data <= byte_sel(r_word[0], w_bsel[0]);
      r1_data <= byte_sel(r_word[1], w_bsel[1]);
      r2_data <= byte_sel(r_word[2], w_bsel[2]);
    end
  end

endmodule

// File: tb/tb_jtbubl_romarb.sv
// Directed scenarios followed by a randomized run checked against a ROM-content model.
module tb_jtbubl_romarb;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             inv = 1'b0;
  logic [2:0]       cs_v = 3'b000;
  logic [2:0][15:0] addr_v = '0;
  wire  [2:0][7:0]  data_v;
  wire  [2:0]       ok_v;
  wire              sdram_req;
  wire  [21:0]      sdram_addr;
  logic             sdram_ack = 1'b0;
  logic             data_rdy = 1'b0;
  logic [15:0]      data_din = 16'h0000;

  int n_assert = 0;
  int n_fail   = 0;

  localparam logic [21:0] OFFS [3] = '{22'h000000, 22'h004000, 22'h006000};

  always #5 clk = ~clk;

  jtbubl_romarb u_dut (
    .clk(clk), .rst(rst), .inv(inv),
    .r0_cs(cs_v[0]), .r0_addr(addr_v[0]), .r0_data(data_v[0]), .r0_ok(ok_v[0]),
    .r1_cs(cs_v[1]), .r1_addr(addr_v[1]), .r1_data(data_v[1]), .r1_ok(ok_v[1]),
    .r2_cs(cs_v[2]), .r2_addr(addr_v[2]), .r2_data(data_v[2]), .r2_ok(ok_v[2]),
    .sdram_req(sdram_req), .sdram_addr(sdram_addr), .sdram_ack(sdram_ack),
    .data_rdy(data_rdy), .data_din(data_din)
  );

  function automatic logic [15:0] rom_word(input logic [21:0] a);
    return (a[15:0] * 16'd40503) ^ {10'd0, a[21:16]} ^ 16'h5AC3;
  endfunction

  function automatic logic [7:0] exp_byte(input int n, input logic [15:0] ba);
    logic [21:0] w;
    logic [15:0] d;
    w = OFFS[n] + {7'd0, ba[15:1]};
    d = rom_word(w);
    return ba[0] ? d[15:8] : d[7:0];
  endfunction

  function automatic logic [15:0] rand_addr();
    logic [15:0] a;
    a = {2'b00, 2'($urandom_range(3)), 9'd0, 3'($urandom_range(7))};
    return a;
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_req(input string tag);
    int k;
    k = 0;
    while (!sdram_req && k < 30) begin
      tick();
      k++;
    end
    chk(tag, {31'd0, sdram_req}, 32'd1);
  endtask

  // sdram_req is high on entry; leaves at the negedge after the fill edge
  task automatic serve(input int ack_wait, input int data_wait, input logic [15:0] d);
    repeat (ack_wait) tick();
    sdram_ack = 1'b1;
    if (data_wait == 0) begin
      data_rdy = 1'b1;
      data_din = d;
    end
    tick();
    sdram_ack = 1'b0;
    data_rdy  = 1'b0;
    if (data_wait > 0) begin
      repeat (data_wait - 1) tick();
      data_rdy = 1'b1;
      data_din = d;
      tick();
      data_rdy = 1'b0;
    end
  endtask

  int          wt [3];
  int          pend_cnt;
  logic [21:0] pend_addr;

  initial begin
    // reset state
    repeat (3) tick();
    chk("rst_ok", {29'd0, ok_v}, 32'd0);
    chk("rst_data", {8'd0, data_v}, 32'd0);
    chk("rst_req", {31'd0, sdram_req}, 32'd0);
    chk("rst_addr", {10'd0, sdram_addr}, 32'd0);
    rst = 1'b0;
    tick();

    // single miss, then a hit on the other byte of the same word
    cs_v[0] = 1'b1; addr_v[0] = 16'h0003;
    tick();
    chk("t1_req", {31'd0, sdram_req}, 32'd1);
    chk("t1_addr", {10'd0, sdram_addr}, 32'h000001);
    serve(1, 3, 16'hA55A);
    chk("t1_ok_lat", {31'd0, ok_v[0]}, 32'd0);
    tick();
    chk("t1_ok", {31'd0, ok_v[0]}, 32'd1);
    chk("t1_data", {24'd0, data_v[0]}, 32'hA5);
    addr_v[0] = 16'h0002;
    tick();
    chk("t1_hit_ok", {31'd0, ok_v[0]}, 32'd1);
    chk("t1_hit_data", {24'd0, data_v[0]}, 32'h5A);
    chk("t1_hit_noreq", {31'd0, sdram_req}, 32'd0);

    // three simultaneous misses, twice
    rst = 1'b1; cs_v = 3'b000;
    tick();
    rst = 1'b0;
    cs_v = 3'b111;
    addr_v[0] = 16'h0020; addr_v[1] = 16'h0041; addr_v[2] = 16'h0010;
    tick();
    chk("t2_req0", {31'd0, sdram_req}, 32'd1);
    chk("t2_addr0", {10'd0, sdram_addr}, 32'h000010);
    serve(1, 1, 16'h1111);
    wait_req("t2_req1");
    chk("t2_addr1", {10'd0, sdram_addr}, 32'h004020);
    serve(0, 2, 16'h2222);
    wait_req("t2_req2");
    chk("t2_addr2", {10'd0, sdram_addr}, 32'h006008);
    serve(2, 0, 16'h3333);
    tick();
    chk("t2_oks", {29'd0, ok_v}, 32'h7);
    chk("t2_data", {8'd0, data_v}, 32'h332211);
    addr_v[0] = 16'h0030; addr_v[1] = 16'h0061; addr_v[2] = 16'h0012;
    tick();
    chk("t2b_addr0", {10'd0, sdram_addr}, 32'h000018);
    serve(0, 1, 16'h4444);
    wait_req("t2b_req1");
    chk("t2b_addr1", {10'd0, sdram_addr}, 32'h004030);
    serve(0, 1, 16'h5555);
    wait_req("t2b_req2");
    chk("t2b_addr2", {10'd0, sdram_addr}, 32'h006009);
    serve(0, 1, 16'h6666);

    // r1 address moves while its fetch is in flight
    cs_v = 3'b010; addr_v[1] = 16'h0100;
    tick();
    chk("t3_addr0", {10'd0, sdram_addr}, 32'h004080);
    tick();
    sdram_ack = 1'b1;
    tick();
    sdram_ack = 1'b0;
    addr_v[1] = 16'h0200;
    tick();
    data_rdy = 1'b1; data_din = 16'hBEEF;
    tick();
    data_rdy = 1'b0;
    chk("t3_ok_a", {31'd0, ok_v[1]}, 32'd0);
    tick();
    chk("t3_ok_b", {31'd0, ok_v[1]}, 32'd0);
    wait_req("t3_req");
    chk("t3_addr1", {10'd0, sdram_addr}, 32'h004100);
    serve(1, 1, 16'hCAFE);
    tick();
    chk("t3_ok", {31'd0, ok_v[1]}, 32'd1);
    chk("t3_data", {24'd0, data_v[1]}, 32'hFE);

    // r0 and r2 miss together after r1 was granted: r2 goes first; inv makes its data stale
    cs_v = 3'b101; addr_v[0] = 16'h0200; addr_v[2] = 16'h0040;
    tick();
    chk("t4_rr_addr", {10'd0, sdram_addr}, 32'h006020);
    tick();
    sdram_ack = 1'b1;
    tick();
    sdram_ack = 1'b0;
    inv = 1'b1;
    tick();
    inv = 1'b0;
    data_rdy = 1'b1; data_din = 16'h7777;
    tick();
    data_rdy = 1'b0;
    chk("t4_stale_ok", {31'd0, ok_v[2]}, 32'd0);
    wait_req("t4_req0");
    chk("t4_addr0", {10'd0, sdram_addr}, 32'h000100);
    serve(0, 1, 16'h8888);
    wait_req("t4_req2");
    chk("t4_refetch", {10'd0, sdram_addr}, 32'h006020);
    serve(0, 1, 16'h9999);
    tick();
    chk("t4_ok", {29'd0, ok_v}, 32'h5);
    chk("t4_data0", {24'd0, data_v[0]}, 32'h88);
    chk("t4_data2", {24'd0, data_v[2]}, 32'h99);

    // ack and data in the same cycle, then data_rdy while idle
    cs_v = 3'b001; addr_v[0] = 16'h0101;
    tick();
    chk("t5_addr", {10'd0, sdram_addr}, 32'h000080);
    serve(0, 0, 16'h1234);
    chk("t5_ok_lat", {31'd0, ok_v[0]}, 32'd0);
    chk("t5_req_lo", {31'd0, sdram_req}, 32'd0);
    tick();
    chk("t5_ok", {31'd0, ok_v[0]}, 32'd1);
    chk("t5_data", {24'd0, data_v[0]}, 32'h12);
    data_rdy = 1'b1; data_din = 16'hFFFF;
    tick();
    data_rdy = 1'b0;
    tick();
    chk("t5_idle_data", {24'd0, data_v[0]}, 32'h12);
    chk("t5_idle_req", {31'd0, sdram_req}, 32'd0);
    addr_v[0] = 16'h0100;
    tick();
    chk("t5_lo_data", {24'd0, data_v[0]}, 32'h34);

    // reset during WAIT_ACK
    cs_v = 3'b011; addr_v[1] = 16'h0300;
    tick();
    chk("t6_addr", {10'd0, sdram_addr}, 32'h004180);
    tick();
    rst = 1'b1;
    tick();
    chk("t6_rst_ok", {29'd0, ok_v}, 32'd0);
    chk("t6_rst_data", {8'd0, data_v}, 32'd0);
    chk("t6_rst_req", {31'd0, sdram_req}, 32'd0);
    chk("t6_rst_addr", {10'd0, sdram_addr}, 32'd0);
    rst = 1'b0;
    data_rdy = 1'b1; data_din = 16'hDEAD;
    tick();
    data_rdy = 1'b0;
    chk("t6_remiss_req", {31'd0, sdram_req}, 32'd1);
    chk("t6_remiss_addr", {10'd0, sdram_addr}, 32'h000080);
    chk("t6_remiss_ok", {31'd0, ok_v[0]}, 32'd0);
    serve(1, 0, 16'h5678);
    tick();
    chk("t6_ok0", {31'd0, ok_v[0]}, 32'd1);
    chk("t6_data0", {24'd0, data_v[0]}, 32'h78);
    wait_req("t6_req1");
    chk("t6_addr1", {10'd0, sdram_addr}, 32'h004180);
    serve(0, 0, 16'h4321);
    tick();
    chk("t6_data1", {24'd0, data_v[1]}, 32'h21);

    // randomized traffic against the ROM-content model
    rst = 1'b1; cs_v = 3'b000;
    tick();
    tick();
    rst = 1'b0;
    pend_cnt = 0;
    pend_addr = '0;
    for (int n = 0; n < 3; n++) wt[n] = 0;
    for (int c = 0; c < 2000; c++) begin
      tick();
      for (int n = 0; n < 3; n++) begin
        if (!cs_v[n]) chk("rnd_ok_idle", {31'd0, ok_v[n]}, 32'd0);
        else if (ok_v[n]) chk("rnd_data", {24'd0, data_v[n]}, {24'd0, exp_byte(n, addr_v[n])});
      end
      if (pend_cnt > 0) chk("rnd_single", {31'd0, sdram_req}, 32'd0);
      inv = ($urandom_range(63) == 0);
      for (int n = 0; n < 3; n++) begin
        if (!cs_v[n]) begin
          if ($urandom_range(3) == 0) begin
            cs_v[n] = 1'b1;
            addr_v[n] = rand_addr();
            wt[n] = 0;
          end
        end else if (ok_v[n]) begin
          case ($urandom_range(2))
            0: cs_v[n] = 1'b0;
            1: addr_v[n] = rand_addr();
            default: ;
          endcase
          wt[n] = 0;
        end else begin
          wt[n]++;
          if (wt[n] > 150) begin
            chk("rnd_live", {31'd0, ok_v[n]}, 32'd1);
            wt[n] = 0;
          end
        end
      end
      sdram_ack = 1'b0;
      data_rdy  = 1'b0;
      if (pend_cnt > 0) begin
        pend_cnt--;
        if (pend_cnt == 0) begin
          data_rdy = 1'b1;
          data_din = rom_word(pend_addr);
        end
      end else if (sdram_req && $urandom_range(1) == 1) begin
        sdram_ack = 1'b1;
        pend_addr = sdram_addr;
        pend_cnt  = $urandom_range(3);
        if (pend_cnt == 0) begin
          data_rdy = 1'b1;
          data_din = rom_word(pend_addr);
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
